reaction_round_sequencer: RTL and testbench
===========================================

// Module: reaction_round_sequencer
// PURPOSE
// Top-level sequencer for the reaction-time game: runs ROUNDS timed trials per game,
// generating a pseudo-random wait, lighting green, timing the player's hit in ms.
// Tracks the best (minimum) round time and requests a high-score register load when
// beaten. Drives LEDs and display mux select; sits between button inputs and the
// score register / 7-seg display datapath.
// PARAMETERS
// ROUNDS        3      trials per game (1..4)
// SCORE_W       13     width of ms times / scores (max 8191)
// TICK_DIV      50000  clk cycles per 1 ms tick
// DELAY_MIN_MS  1000   minimum random wait before green
// DELAY_RBITS   11     random wait addend = LFSR[DELAY_RBITS-1:0] ms
// TIMEOUT_MS    8191   reaction time cap; no hit by then -> round time = TIMEOUT_MS
// SHOW_MS       2000   time each round result is displayed
// PORTS
// clk           in   1        system clock
// reset         in   1        async active-high reset
// btn_start     in   1        start button, raw level, active-high
// btn_hit       in   1        hit button, raw level, active-high
// btn_clear     in   1        sync soft reset to IDLE (keeps LFSR, not high score)
// hs_value      in   SCORE_W  current high-score register contents (0 = none)
// led_green     out  1        go light
// led_red       out  1        foul light
// disp_sel      out  2        00 round time, 01 best, 10 high score, 11 foul code
// disp_value    out  SCORE_W  value for display datapath
// hs_load       out  1        1-cycle pulse: load hs_load_data into high-score reg
// hs_load_data  out  SCORE_W  new high score
// round_idx     out  2        current round, 0-based
// busy          out  1        high in any state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, disp_sel=10, LFSR=16'hACE1, best=all-ones.
// - Buttons: 2-FF synchroniser then rising-edge detect; edge pulse is 1 clk, seen
//   3 clks after the raw edge. Levels ignored, only edges act.
// - ms tick: prescaler counts 0..TICK_DIV-1, pulses tick at wrap; cleared on every
//   state entry so first tick in a state comes exactly TICK_DIV clks after entry.
// - LFSR: 16-bit Galois, taps 0xB400, advances every clk, never all-zero.
// - States:
//   IDLE   : disp_sel=10, disp_value=hs_value. start edge -> ARM, round_idx=0, best=max.
//   ARM    : 1 clk; delay_ms = DELAY_MIN_MS + LFSR[DELAY_RBITS-1:0] (no overflow,
//            SCORE_W+1 bits). -> WAIT.
//   WAIT   : count ticks; hit edge -> FOUL; count==delay_ms -> GO.
//   GO     : led_green=1, timer counts ticks from 0. Hit edge -> RESULT with
//            t=timer; timer==TIMEOUT_MS -> RESULT with t=TIMEOUT_MS.
//   FOUL   : led_red=1, disp_sel=11, disp_value=TIMEOUT_MS; round time t=TIMEOUT_MS;
//            hold SHOW_MS then -> NEXT.
//   RESULT : disp_sel=00, disp_value=t; best=min(best,t) on entry; hold SHOW_MS -> NEXT.
//   NEXT   : 1 clk; round_idx==ROUNDS-1 -> DONE, else round_idx++ -> ARM.
//   DONE   : disp_sel=01, disp_value=best. On entry, if best<TIMEOUT_MS and
//            (hs_value==0 or best<hs_value): hs_load=1 for 1 clk, hs_load_data=best.
//            start edge -> ARM (new game, round_idx=0, best=max).
// - Hit edges in ARM/RESULT/FOUL/NEXT/DONE ignored; start edges ignored unless IDLE/DONE.
// - Hit edge on same clk as WAIT delay expiry: FOUL wins. Same clk as GO timeout:
//   hit wins, t=TIMEOUT_MS.
// - btn_clear edge: any state -> IDLE next clk, LEDs off, no hs_load. reset anytime:
//   immediate return to reset values, including mid-GO.
// - Outputs registered; led_green rises the clk after entry to GO.
// TESTING (TICK_DIV=4, DELAY_MIN_MS=2, DELAY_RBITS=2, ROUNDS=2, TIMEOUT_MS=20, SHOW_MS=3)
// 1. Start, hit 5 ms after green each round, hs_value=0 -> disp_value=5 per round;
//    DONE: disp_sel=01, best=5, one hs_load pulse with data 5.
// 2. Hit during WAIT round 0 -> led_red=1, disp_sel=11 for 12 clks, round 1 follows;
//    round 1 hit at 7 ms -> best=7.
// 3. No hit in GO -> RESULT t=20 both rounds; DONE best=20, no hs_load.
// 4. hs_value=4, player best=5 -> no hs_load; hs_value=9 -> hs_load, data=5.
// 5. btn_clear mid-GO -> IDLE, led_green=0, busy=0; async reset mid-WAIT -> all outputs 0.
// 6. Hit edge on GO timeout clk -> t=20, no FOUL; start held high in DONE -> only one new game.

Source files
------------

// File: rtl/reaction_round_sequencer.sv
// Reaction-time game sequencer: random wait, green light, ms timing of the hit,
// best-of-game tracking and high-score load requests.
module reaction_round_sequencer #(
  parameter int ROUNDS       = 3,
  parameter int SCORE_W      = 13,
  parameter int TICK_DIV     = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_RBITS  = 11,
  parameter int TIMEOUT_MS   = 8191,
  parameter int SHOW_MS      = 2000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_btn_start,
  input  logic               i_btn_hit,
  input  logic               i_btn_clear,
  input  logic [SCORE_W-1:0] i_hs_value,
  output logic               o_led_green,
  output logic               o_led_red,
  output logic [1:0]         o_disp_sel,
  output logic [SCORE_W-1:0] o_disp_value,
  output logic               o_hs_load,
  output logic [SCORE_W-1:0] o_hs_load_data,
  output logic [1:0]         o_round_idx,
  output logic               o_busy
);
  localparam int MW = SCORE_W + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SCORE_W-1:0] TIMEOUT_V = SCORE_W'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO, S_FOUL, S_RESULT, S_NEXT, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [2:0]         r_sync1, r_sync2, r_prev;
  logic [2:0]         w_btn_raw, w_btn_edge;
  logic               w_start_edge, w_hit_edge, w_clear_edge;
  logic [15:0]        r_lfsr;
  logic [PW-1:0]      r_presc;
  logic               w_tick;
  logic [MW-1:0]      r_ms, w_ms_inc, r_delay;
  logic               w_delay_hit, w_go_timeout, w_show_done;
  logic [SCORE_W-1:0] r_best, r_t, w_t_new;
  logic [1:0]         r_round;
  logic               w_state_change, w_hs_load_next;
  logic [1:0]         w_disp_sel_next;
  logic [SCORE_W-1:0] w_disp_value_next;

  // Buttons: two-stage synchroniser, then rising-edge detect against the previous level.
  assign w_btn_raw    = {i_btn_clear, i_btn_hit, i_btn_start};
  assign w_btn_edge   = r_sync2 & ~r_prev;
  assign w_start_edge = w_btn_edge[0];
  assign w_hit_edge   = w_btn_edge[1];
  assign w_clear_edge = w_btn_edge[2];

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_prev  <= 3'b000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_lfsr <= 16'hACE1;
    else         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Prescaler and ms counter restart on every state change so each state times from its entry.
  assign w_state_change = (w_state_next != r_state);
  assign w_tick         = (r_presc == PW'(TICK_DIV - 1));
  assign w_ms_inc       = r_ms + MW'(1);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else if (w_state_change) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick && (r_ms != '1)) r_ms <= w_ms_inc;
    end
  end

  assign w_delay_hit  = w_tick && (w_ms_inc >= r_delay);
  assign w_go_timeout = w_tick && (w_ms_inc == MW'(TIMEOUT_MS));
  assign w_show_done  = w_tick && (w_ms_inc >= MW'(SHOW_MS));
  assign w_t_new      = w_go_timeout ? TIMEOUT_V : r_ms[SCORE_W-1:0];

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_edge) w_state_next = S_ARM;
      S_ARM:    w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_hit_edge)       w_state_next = S_FOUL;
        else if (w_delay_hit) w_state_next = S_GO;
      end
      S_GO:     if (w_hit_edge || w_go_timeout) w_state_next = S_RESULT;
      S_FOUL:   if (w_show_done) w_state_next = S_NEXT;
      S_RESULT: if (w_show_done) w_state_next = S_NEXT;
      S_NEXT:   w_state_next = (r_round == 2'(ROUNDS - 1)) ? S_DONE : S_ARM;
      S_DONE:   if (w_start_edge) w_state_next = S_ARM;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_clear_edge) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_round <= 2'd0;
      r_best  <= '1;
      r_t     <= '0;
      r_delay <= '0;
    end else begin
      if (r_state == S_ARM)
        r_delay <= MW'(DELAY_MIN_MS) + MW'(r_lfsr[DELAY_RBITS-1:0]);
      if (w_state_next == S_ARM && (r_state == S_IDLE || r_state == S_DONE)) begin
        r_round <= 2'd0;
        r_best  <= '1;
      end else if (w_state_next == S_ARM && r_state == S_NEXT) begin
        r_round <= r_round + 2'd1;
      end else if (w_state_next == S_IDLE) begin
        r_round <= 2'd0;
      end
      if (r_state == S_GO && w_state_next == S_RESULT) begin
        r_t <= w_t_new;
        if (w_t_new < r_best) r_best <= w_t_new;
      end
      if (r_state == S_WAIT && w_state_next == S_FOUL) r_t <= TIMEOUT_V;
    end
  end

  // A missed game (best still at timeout or unset) never becomes a high score.
  assign w_hs_load_next = (r_state == S_NEXT) && (w_state_next == S_DONE) &&
                          (r_best < TIMEOUT_V) &&
                          ((i_hs_value == '0) || (r_best < i_hs_value));

  always_comb begin
    w_disp_sel_next   = 2'b01;
    w_disp_value_next = r_best;
    case (r_state)
      S_IDLE: begin
        w_disp_sel_next   = 2'b10;
        w_disp_value_next = i_hs_value;
      end
      S_FOUL: begin
        w_disp_sel_next   = 2'b11;
        w_disp_value_next = TIMEOUT_V;
      end
      S_RESULT: begin
        w_disp_sel_next   = 2'b00;
        w_disp_value_next = r_t;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_led_green    <= 1'b0;
      o_led_red      <= 1'b0;
      o_busy         <= 1'b0;
      o_disp_sel     <= 2'b10;
      o_disp_value   <= '0;
      o_hs_load      <= 1'b0;
      o_hs_load_data <= '0;
    end else begin
      o_led_green  <= (r_state == S_GO);
      o_led_red    <= (r_state == S_FOUL);
      o_busy       <= (r_state != S_IDLE);
      o_disp_sel   <= w_disp_sel_next;
      o_disp_value <= w_disp_value_next;
      o_hs_load    <= w_hs_load_next;
      if (w_hs_load_next) o_hs_load_data <= r_best;
    end
  end

  assign o_round_idx = r_round;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Self-checking bench for reaction_round_sequencer: scripted and random games
// checked against a timeline model of the game rules.
`timescale 1ns/1ps
module tb_reaction_round_sequencer;
  localparam int T = 4, DMIN = 2, RB = 2, NR = 2, TO = 20, SH = 3, SW = 13;
  localparam logic [SW-1:0] BEST_MAX = {SW{1'b1}};

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, hit = 1'b0, clr = 1'b0;
  logic [SW-1:0] hs = '0;
  logic          o_led_green, o_led_red, o_hs_load, o_busy;
  logic [1:0]    o_disp_sel, o_round_idx;
  logic [SW-1:0] o_disp_value, o_hs_load_data;
  logic [15:0]   m_lfsr;
  int            n_cmp = 0, n_bad = 0, hs_cnt = 0;
  logic [SW-1:0] hs_last = '0;

  always #5 clk = ~clk;

  reaction_round_sequencer #(
    .ROUNDS(NR), .SCORE_W(SW), .TICK_DIV(T), .DELAY_MIN_MS(DMIN),
    .DELAY_RBITS(RB), .TIMEOUT_MS(TO), .SHOW_MS(SH)
  ) dut (
    .clk(clk), .i_reset(rst), .i_btn_start(start), .i_btn_hit(hit),
    .i_btn_clear(clr), .i_hs_value(hs), .o_led_green(o_led_green),
    .o_led_red(o_led_red), .o_disp_sel(o_disp_sel), .o_disp_value(o_disp_value),
    .o_hs_load(o_hs_load), .o_hs_load_data(o_hs_load_data),
    .o_round_idx(o_round_idx), .o_busy(o_busy)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Hit raw set k negedges after green is first seen: the edge is acted on c=3+k clks
  // after GO entry, i.e. in ms c/T; the last clk before the timeout still reports TO.
  function automatic int t_of_k(input int k);
    int c;
    c = 3 + k;
    return (c >= TO * T - 1) ? TO : c / T;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);

  always @(negedge clk)
    if (o_hs_load) begin
      hs_cnt  <= hs_cnt + 1;
      hs_last <= o_hs_load_data;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // k >= 0: hit k clks after green seen; -1: foul in WAIT (round 0 only); -2: no hit.
  task automatic play_game(input string tag, input logic [SW-1:0] hsv,
                           input int k0, input int k1, input bit hold);
    int ks[2];
    int n, d, t;
    int hs0;
    logic [15:0]   lf;
    logic [SW-1:0] best;
    bit exp_load;
    ks[0] = k0; ks[1] = k1;
    best = BEST_MAX; hs = hsv; hs0 = hs_cnt;
    @(negedge clk);
    start = 1'b1;
    lf = lfsr_step(lfsr_step(lfsr_step(m_lfsr)));
    d  = DMIN + int'(lf[RB-1:0]);
    n  = 0;
    repeat (2) begin @(negedge clk); n++; end
    if (!hold) start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (ks[r] == -1) begin
        repeat (2) begin @(negedge clk); n++; end
        hit = 1'b1; n = 0;
        while (o_led_red !== 1'b1 && n < 20) begin
          @(negedge clk); n++;
          if (n == 2) hit = 1'b0;
        end
        hit = 1'b0;
        n_cmp++;
        if (n != 4) begin n_bad++; $display("FAIL %s red_latency: got %0d expected 4", tag, n); end
        n_cmp++;
        if (o_disp_sel !== 2'b11 || o_disp_value !== SW'(TO)) begin
          n_bad++; $display("FAIL %s foul_disp: got sel=%b val=%0d expected sel=11 val=%0d", tag, o_disp_sel, o_disp_value, TO);
        end
        n = 0;
        while (o_led_red === 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (n != SH * T) begin n_bad++; $display("FAIL %s foul_hold: got %0d expected %0d", tag, n, SH * T); end
        $display("%s round %0d: foul, red held %0d clks", tag, r, n);
      end else begin
        while (o_led_green !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        n_cmp++;
        if (o_led_green !== 1'b1) begin n_bad++; $display("FAIL %s green_wait: got %b expected 1", tag, o_led_green); end
        if (r == 0) begin
          n_cmp++;
          if (n != 5 + d * T) begin n_bad++; $display("FAIL %s green_delay: got %0d expected %0d", tag, n, 5 + d * T); end
        end
        n_cmp++;
        if (o_round_idx !== 2'(r)) begin n_bad++; $display("FAIL %s round_idx: got %0d expected %0d", tag, o_round_idx, r); end
        n = 0;
        if (ks[r] == -2) begin
          t = TO;
          while (o_disp_sel !== 2'b00 && n < 200) begin @(negedge clk); n++; end
          n_cmp++;
          if (n != TO * T) begin n_bad++; $display("FAIL %s timeout_latency: got %0d expected %0d", tag, n, TO * T); end
        end else begin
          t = t_of_k(ks[r]);
          repeat (ks[r]) @(negedge clk);
          hit = 1'b1;
          while (o_disp_sel !== 2'b00 && n < 20) begin
            @(negedge clk); n++;
            if (n == 2) hit = 1'b0;
          end
          hit = 1'b0;
          n_cmp++;
          if (n != 4) begin n_bad++; $display("FAIL %s result_latency: got %0d expected 4", tag, n); end
        end
        n_cmp++;
        if (o_disp_value !== SW'(t) || o_led_red !== 1'b0) begin
          n_bad++; $display("FAIL %s round_time: got %0d red=%b expected %0d red=0", tag, o_disp_value, o_led_red, t);
        end
        if (SW'(t) < best) best = SW'(t);
        $display("%s round %0d: k=%0d time=%0d ms", tag, r, ks[r], o_disp_value);
        n = 0;
      end
    end
    repeat (14) @(negedge clk);
    exp_load = (best < SW'(TO)) && (hsv == '0 || best < hsv);
    n_cmp++;
    if (o_disp_sel !== 2'b01 || o_disp_value !== best || o_busy !== 1'b1 || o_round_idx !== 2'(NR - 1)) begin
      n_bad++; $display("FAIL %s done_disp: got sel=%b val=%0d busy=%b idx=%0d expected sel=01 val=%0d busy=1 idx=%0d",
                        tag, o_disp_sel, o_disp_value, o_busy, o_round_idx, best, NR - 1);
    end
    n_cmp++;
    if (hs_cnt - hs0 != int'(exp_load)) begin
      n_bad++; $display("FAIL %s hs_load_count: got %0d expected %0d", tag, hs_cnt - hs0, int'(exp_load));
    end
    if (exp_load) begin
      n_cmp++;
      if (hs_last !== best) begin n_bad++; $display("FAIL %s hs_load_data: got %0d expected %0d", tag, hs_last, best); end
    end
    $display("%s done: best=%0d hs_value=%0d hs_load=%0d", tag, o_disp_value, hsv, hs_cnt - hs0);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (o_led_green !== 1'b0 || o_led_red !== 1'b0 || o_busy !== 1'b0 || o_disp_sel !== 2'b10 ||
        o_disp_value !== '0 || o_hs_load !== 1'b0 || o_hs_load_data !== '0 || o_round_idx !== 2'b00) begin
      n_bad++; $display("FAIL reset_outputs: got g=%b r=%b busy=%b sel=%b val=%0d expected all 0 sel=10",
                        o_led_green, o_led_red, o_busy, o_disp_sel, o_disp_value);
    end
    hs = SW'(123);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_disp_sel !== 2'b10 || o_disp_value !== SW'(123) || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_disp: got sel=%b val=%0d busy=%b expected sel=10 val=123 busy=0", o_disp_sel, o_disp_value, o_busy);
    end
    $display("reset: idle shows hs_value %0d", o_disp_value);
  endtask

  task automatic test_basic_game();
    play_game("basic", '0, 18, 18, 1'b0);
  endtask

  task automatic test_foul();
    play_game("foul", '0, -1, 26, 1'b0);
  endtask

  task automatic test_timeout();
    play_game("timeout", '0, -2, -2, 1'b0);
  endtask

  task automatic test_hs_compare();
    play_game("hs_above", SW'(4), 18, 18, 1'b0);
    play_game("hs_below", SW'(9), 18, 18, 1'b0);
  endtask

  task automatic test_timeout_edge();
    play_game("to_edge", '0, 76, 75, 1'b0);
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 5; g++) begin
      int k0;
      k0 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 75));
      play_game($sformatf("rand%0d", g), SW'($urandom_range(0, 25)), k0, int'($urandom_range(0, 75)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    play_game("held_start", '0, int'($urandom_range(0, 75)), int'($urandom_range(0, 75)), 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_round_idx !== 2'(NR - 1) || o_led_green !== 1'b0 || o_disp_sel !== 2'b01) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL held_start_single_game: got restart expected stay in done"); end
    start = 1'b0;
    $display("held_start: start held 40 clks in done, idx=%0d", o_round_idx);
  endtask

  task automatic test_clear_and_reset();
    int n, hs0;
    hs = SW'(77); hs0 = hs_cnt;
    @(negedge clk); start = 1'b1;
    repeat (2) @(negedge clk); start = 1'b0;
    n = 0;
    while (o_led_green !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    clr = 1'b1; n = 0;
    while (o_busy !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
      if (n == 2) clr = 1'b0;
    end
    clr = 1'b0;
    n_cmp++;
    if (n != 4 || o_led_green !== 1'b0 || o_disp_sel !== 2'b10 || o_disp_value !== SW'(77)) begin
      n_bad++; $display("FAIL clear_mid_go: got lat=%0d g=%b sel=%b val=%0d expected lat=4 g=0 sel=10 val=77",
                        n, o_led_green, o_disp_sel, o_disp_value);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (hs_cnt != hs0) begin n_bad++; $display("FAIL clear_no_hs_load: got %0d expected %0d", hs_cnt, hs0); end
    $display("clear: mid-GO clear returned to idle after %0d clks", n);
    start = 1'b1;
    repeat (2) @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (o_led_green !== 1'b0 || o_led_red !== 1'b0 || o_busy !== 1'b0 || o_disp_sel !== 2'b10 ||
        o_disp_value !== '0 || o_hs_load !== 1'b0 || o_hs_load_data !== '0 || o_round_idx !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_wait: got busy=%b sel=%b val=%0d hsd=%0d expected busy=0 sel=10 val=0 hsd=0",
                        o_busy, o_disp_sel, o_disp_value, o_hs_load_data);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_disp_value !== SW'(77)) begin
      n_bad++; $display("FAIL after_reset_idle: got busy=%b val=%0d expected busy=0 val=77", o_busy, o_disp_value);
    end
    $display("reset: asynchronous reset mid-WAIT cleared outputs");
  endtask

  initial begin
    test_reset();
    test_basic_game();
    test_foul();
    test_timeout();
    test_hs_compare();
    test_timeout_edge();
    test_random_games();
    test_back_to_back();
    test_clear_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
